// File: rtl/minibyte_mem_arbiter_if.sv
// MiniByte memory-arbiter bus bundle: CPU and debug requester ports, ROM port,
// output latch, external req/ack bus and error pulse.
interface minibyte_mem_arbiter_if #(
  parameter int ROM_AW = 5
);
  logic              cpu_req, cpu_we, cpu_ack;
  logic [7:0]        cpu_addr, cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_ack;
  logic [7:0]        dbg_addr, dbg_wdata, dbg_rdata;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        out_reg;
  logic              ext_req, ext_we, ext_ack;
  logic [7:0]        ext_addr, ext_wdata, ext_rdata;
  logic              err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output rom_addr, input rom_data,
    output out_reg,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  rom_addr, output rom_data,
    input  out_reg,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    input  err
  );
endinterface

// File: rtl/minibyte_mem_arbiter.sv
// Two-requester (CPU / debug host) memory arbiter decoding to ROM, output latch or external bus.
// Optional MINIBYTE_ARB_DBG_PRIO_EN: debug host wins every tie instead of round-robin.
module minibyte_mem_arbiter #(
  parameter int          ROM_AW   = 5,
  parameter logic [7:0]  OUT_ADDR = 8'h40,
  parameter int          EXT_TMO  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  minibyte_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_ROM, S_OUT, S_EXT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              gnt_dbg_q, we_q;
  logic [7:0]        addr_q, wdata_q, out_q, cpu_rd_q, dbg_rd_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [3:0]        cnt_q, cnt_nxt;
  logic              err_q, err_d, cap_en, out_we, tmo;
  logic [7:0]        cap_val;

  logic       any_req, pick_dbg, sel_we, is_rom;
  logic [7:0] sel_addr, sel_wdata;

  assign any_req = bus.cpu_req | bus.dbg_req;

`ifdef MINIBYTE_ARB_DBG_PRIO_EN
  assign pick_dbg = bus.dbg_req;
`else
  logic rr_last_q;  // 1: debug host held the most recent grant
  assign pick_dbg = bus.dbg_req & (~bus.cpu_req | ~rr_last_q);
`endif

  assign sel_we    = pick_dbg ? bus.dbg_we    : bus.cpu_we;
  assign sel_addr  = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  assign is_rom    = (sel_addr >> ROM_AW) == 8'd0;

  assign cnt_nxt = cnt_q + 4'd1;
  assign tmo     = ~bus.ext_ack & (cnt_nxt == 4'(EXT_TMO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    cap_val = '0;
    err_d   = 1'b0;
    out_we  = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (any_req) begin
          if (is_rom)                     state_d = S_ROM;
          else if (sel_addr == OUT_ADDR)  state_d = S_OUT;
          else                            state_d = S_EXT;
        end
      S_ROM: begin
        state_d = S_DONE;
        if (we_q) err_d = 1'b1;
        else begin
          cap_en  = 1'b1;
          cap_val = bus.rom_data;
        end
      end
      S_OUT: begin
        state_d = S_DONE;
        if (we_q) out_we = 1'b1;
        else begin
          cap_en  = 1'b1;
          cap_val = out_q;
        end
      end
      S_EXT:
        // an ack arriving on the timeout edge takes precedence
        if (bus.ext_ack) begin
          state_d = S_DONE;
          cap_en  = ~we_q;
          cap_val = bus.ext_rdata;
        end else if (tmo) begin
          state_d = S_DONE;
          cap_en  = 1'b1;
          cap_val = 8'hFF;
          err_d   = 1'b1;
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_dbg_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rom_addr_q <= '0;
      out_q      <= '0;
      cpu_rd_q   <= '0;
      dbg_rd_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
`ifndef MINIBYTE_ARB_DBG_PRIO_EN
      rr_last_q  <= 1'b0;
`endif
    end else begin
      err_q <= err_d;
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (any_req) begin
          gnt_dbg_q <= pick_dbg;
          we_q      <= sel_we;
          addr_q    <= sel_addr;
          wdata_q   <= sel_wdata;
          if (is_rom) rom_addr_q <= sel_addr[ROM_AW-1:0];
`ifndef MINIBYTE_ARB_DBG_PRIO_EN
          rr_last_q <= pick_dbg;
`endif
        end
      end else if (state_q == S_EXT) begin
        cnt_q <= cnt_nxt;
      end
      if (out_we) out_q <= wdata_q;
      if (cap_en) begin
        if (gnt_dbg_q) dbg_rd_q <= cap_val;
        else           cpu_rd_q <= cap_val;
      end
    end
  end

  assign bus.cpu_ack   = (state_q == S_DONE) & ~gnt_dbg_q;
  assign bus.dbg_ack   = (state_q == S_DONE) &  gnt_dbg_q;
  assign bus.cpu_rdata = cpu_rd_q;
  assign bus.dbg_rdata = dbg_rd_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_reg   = out_q;
  assign bus.ext_req   = (state_q == S_EXT);
  assign bus.ext_we    = (state_q == S_EXT) & we_q;
  assign bus.ext_addr  = addr_q;
  assign bus.ext_wdata = wdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_minibyte_mem_arbiter.sv
// Directed scoreboard bench for minibyte_mem_arbiter; honours MINIBYTE_ARB_DBG_PRIO_EN.
module tb_minibyte_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minibyte_mem_arbiter_if #(.ROM_AW(5)) bus ();

  minibyte_mem_arbiter #(.ROM_AW(5), .OUT_ADDR(8'h40), .EXT_TMO(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM image: each byte holds its address plus one
  assign bus.rom_data = {3'b000, bus.rom_addr} + 8'd1;

  typedef struct {
    bit         dbg;
    logic [7:0] rdata;
    logic       err;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_out, m_cpu_rd, m_dbg_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.ext_ack = 0; bus.ext_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    m_out = '0; m_cpu_rd = '0; m_dbg_rd = '0;
  endtask

  // Drive a request and push the outcome the reference model predicts for it.
  task automatic req(input bit dbg, input bit we, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] ext_val, input bit tmo, input bit front, input string tag);
    exp_t       e;
    logic [7:0] prev;
    prev = dbg ? m_dbg_rd : m_cpu_rd;
    e.dbg = dbg; e.tag = tag; e.err = 1'b0; e.rdata = prev;
    if (a < 8'h20) begin
      if (we) e.err = 1'b1;
      else    e.rdata = a + 8'd1;
    end else if (a == 8'h40) begin
      if (we) m_out = d;
      else    e.rdata = m_out;
    end else if (tmo) begin
      e.rdata = 8'hFF;
      e.err   = 1'b1;
    end else if (!we) begin
      e.rdata = ext_val;
    end
    if (dbg) begin
      m_dbg_rd = e.rdata;
      bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    end else begin
      m_cpu_rd = e.rdata;
      bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
    if (front) sb.push_front(e);
    else       sb.push_back(e);
  endtask

  // Wait (bounded) for an ack, compare against the scoreboard head, then drop that req.
  task automatic wait_ack(input int exp_lat);
    exp_t e;
    bit   got = 0;
    int   lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cpu_ack || bus.dbg_ack) begin
        got = 1;
        lat = i;
        break;
      end
      tick();
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.tag, "/dbg_ack"}, 32'(bus.dbg_ack), 32'(e.dbg));
    chk({e.tag, "/cpu_ack"}, 32'(bus.cpu_ack), 32'(!e.dbg));
    chk({e.tag, "/rdata"}, 32'(e.dbg ? bus.dbg_rdata : bus.cpu_rdata), 32'(e.rdata));
    chk({e.tag, "/err"}, 32'(bus.err), 32'(e.err));
    if (exp_lat >= 0) chk({e.tag, "/latency"}, 32'(lat), 32'(exp_lat));
    if (e.dbg) bus.dbg_req = 0;
    else       bus.cpu_req = 0;
    tick();
    chk({e.tag, "/ack_pulse"}, 32'(bus.cpu_ack | bus.dbg_ack), 32'd0);
    chk({e.tag, "/err_pulse"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst/cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst/ext_req", 32'(bus.ext_req), 32'd0);
    chk("rst/err", 32'(bus.err), 32'd0);
    chk("rst/out_reg", 32'(bus.out_reg), 32'd0);
    chk("rst/rom_addr", 32'(bus.rom_addr), 32'd0);

    // ROM read
    req(0, 0, 8'h04, 8'h00, 8'h00, 0, 0, "rom_rd");
    tick();
    chk("rom_rd/rom_addr", 32'(bus.rom_addr), 32'h04);
    chk("rom_rd/early_ack", 32'(bus.cpu_ack), 32'd0);
    wait_ack(1);

    // Output latch write then read from the debug side
    req(0, 1, 8'h40, 8'hA5, 8'h00, 0, 0, "out_wr");
    wait_ack(2);
    chk("out_wr/out_reg", 32'(bus.out_reg), 32'hA5);
    req(1, 0, 8'h40, 8'h00, 8'h00, 0, 0, "out_rd");
    wait_ack(2);

    // ROM write: err with ack, nothing else changes
    req(0, 1, 8'h10, 8'h77, 8'h00, 0, 0, "rom_wr");
    wait_ack(2);
    chk("rom_wr/out_reg", 32'(bus.out_reg), 32'hA5);

    // External read, ack after 3 cycles of ext_req
    req(0, 0, 8'h80, 8'h00, 8'h3C, 0, 0, "ext_rd");
    tick();
    chk("ext_rd/ext_req", 32'(bus.ext_req), 32'd1);
    chk("ext_rd/ext_addr", 32'(bus.ext_addr), 32'h80);
    chk("ext_rd/ext_we", 32'(bus.ext_we), 32'd0);
    tick(); tick();
    bus.ext_ack = 1; bus.ext_rdata = 8'h3C;
    tick();
    bus.ext_ack = 0; bus.ext_rdata = 8'h00;
    chk("ext_rd/ext_req_drop", 32'(bus.ext_req), 32'd0);
    wait_ack(0);

    // External write from debug, immediate ack
    req(1, 1, 8'h90, 8'h5A, 8'h00, 0, 0, "ext_wr");
    tick();
    chk("ext_wr/ext_we", 32'(bus.ext_we), 32'd1);
    chk("ext_wr/ext_wdata", 32'(bus.ext_wdata), 32'h5A);
    bus.ext_ack = 1;
    tick();
    bus.ext_ack = 0;
    wait_ack(0);

    // External timeout
    req(0, 0, 8'h81, 8'h00, 8'h00, 1, 0, "ext_tmo");
    tick();
    n = 0;
    while (bus.ext_req && n < 40) begin
      n++;
      tick();
    end
    chk("ext_tmo/req_cycles", 32'(n), 32'd15);
    wait_ack(0);

    // Async reset in the middle of an external transaction
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h82;
    tick();
    chk("arst/ext_req_before", 32'(bus.ext_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst/ext_req_drop", 32'(bus.ext_req), 32'd0);
    chk("arst/no_ack", 32'(bus.cpu_ack), 32'd0);
    bus.cpu_req = 0;
    tick(); tick();
    rst_n = 1'b1;
    m_out = '0; m_cpu_rd = '0; m_dbg_rd = '0;
    tick(); tick();
    chk("arst/no_ack_after", 32'(bus.cpu_ack), 32'd0);
    chk("arst/out_reg", 32'(bus.out_reg), 32'd0);
    chk("arst/cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    req(0, 0, 8'h07, 8'h00, 8'h00, 0, 0, "arst_idle");
    wait_ack(2);

    // Tie: debug wins first; debug re-requests after its ack
    req(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, "tie_dbg1");
    req(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, "tie_cpu");
    wait_ack(2);
`ifdef MINIBYTE_ARB_DBG_PRIO_EN
    req(1, 0, 8'h02, 8'h00, 8'h00, 0, 1, "tie_dbg2");
`else
    req(1, 0, 8'h02, 8'h00, 8'h00, 0, 0, "tie_dbg2");
`endif
    wait_ack(2);
    wait_ack(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
